// File: rtl/mux_input_arbiter_if.sv
// Channel-side and selector-side signals of mux_input_arbiter.
// The master modport is the environment; the slave modport is the arbiter.
interface mux_input_arbiter_if #(
  parameter int INPORTWIDTH    = 4,
  parameter int INPORTCNT      = 2,
  parameter int SELECTORLENGTH = 1
);
  logic [INPORTWIDTH*INPORTCNT-1:0] in_data;
  logic [INPORTCNT-1:0]             in_valid;
  logic [INPORTCNT-1:0]             in_ready;
  logic [INPORTWIDTH*INPORTCNT-1:0] inputPort;
  logic [SELECTORLENGTH-1:0]        selector;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, inputPort, selector, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, inputPort, selector, out_valid
  );
endinterface

// File: rtl/mux_input_arbiter.sv
// One-word-per-channel buffer with a registered selector feeding the mux stage.
// Define MUX_ARB_FIXED_PRIORITY_EN for fixed priority; default is round robin.
//
// state | meaning
// IDLE  | nothing granted, out_valid low
// GRANT | selector holds a full channel, out_valid high until out_ready
module mux_input_arbiter #(
  parameter int INPORTWIDTH    = 4,
  parameter int INPORTCNT      = 2,
  parameter int SELECTORLENGTH = 1
) (
  input logic               clk,
  input logic               rst,
  mux_input_arbiter_if.slave bus
);
  localparam int SLOTS = 1 << SELECTORLENGTH;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                           state_q, state_d;
  logic [SELECTORLENGTH-1:0]        sel_q, sel_d;
  logic [INPORTCNT-1:0]             full_q, full_d;
  logic [INPORTCNT-1:0]             accept;
  logic [INPORTWIDTH*INPORTCNT-1:0] hold_q;
  logic [SELECTORLENGTH-1:0]        arb_last, idx, winner;
  logic [SLOTS-1:0]                 req_pad, drain_pad;
  logic                             found;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
  logic [SELECTORLENGTH-1:0]        last_q, last_d;
`endif

  assign bus.in_ready  = ~full_q & {INPORTCNT{~rst}};
  assign bus.inputPort = hold_q;
  assign bus.selector  = sel_q;
  assign bus.out_valid = (state_q == GRANT);
  assign accept        = bus.in_valid & bus.in_ready;
  assign drain_pad     = SLOTS'(1) << sel_q;

  // Requests are padded to a power of two so the search index wraps for free;
  // unused slots are never set, so skipping them equals wrapping at INPORTCNT.
  always_comb begin
`ifdef MUX_ARB_FIXED_PRIORITY_EN
    arb_last = '1;
`else
    arb_last = (state_q == GRANT) ? sel_q : last_q;
`endif
    req_pad = SLOTS'(full_q);
    if (state_q == GRANT) req_pad = req_pad & ~drain_pad;
    found  = 1'b0;
    winner = '0;
    idx    = arb_last;
    for (int k = 0; k < SLOTS; k++) begin
      idx = idx + SELECTORLENGTH'(1);
      if (!found && req_pad[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    full_d  = full_q | accept;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.out_ready) begin
          full_d = full_d & ~drain_pad[INPORTCNT-1:0];
`ifndef MUX_ARB_FIXED_PRIORITY_EN
          last_d = sel_q;
`endif
          if (found) sel_d = winner;
          else       state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      full_q  <= '0;
      hold_q  <= '0;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
      last_q  <= SELECTORLENGTH'(INPORTCNT - 1);
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      full_q  <= full_d;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
      for (int i = 0; i < INPORTCNT; i++) begin
        if (accept[i]) hold_q[i*INPORTWIDTH +: INPORTWIDTH] <= bus.in_data[i*INPORTWIDTH +: INPORTWIDTH];
      end
    end
  end
endmodule

// File: tb/tb_mux_input_arbiter.sv
// Bench for mux_input_arbiter: directed scenarios plus random traffic against a
// pending-word model with a per-channel scoreboard.
module tb_mux_input_arbiter;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int SL = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_input_arbiter_if #(.INPORTWIDTH(W), .INPORTCNT(N), .SELECTORLENGTH(SL)) bus ();

  mux_input_arbiter #(.INPORTWIDTH(W), .INPORTCNT(N), .SELECTORLENGTH(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  bit           m_full [N];
  logic [W-1:0] m_hold [N];
  bit           m_valid;
  int           m_sel;
  int           m_last;
  logic [W-1:0] sb [N][$];
  int           hs_sel [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // First full channel after the last grant, wrapping; excl is the drained one.
  function automatic int pick(input int excl);
    int start;
`ifdef MUX_ARB_FIXED_PRIORITY_EN
    start = N - 1;
`else
    start = m_last;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (start + k) % N;
      if (m_full[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_hold[i] = '0;
      sb[i].delete();
    end
    m_valid = 1'b0;
    m_sel   = 0;
    m_last  = N - 1;
  endtask

  task automatic cycle(input bit r, input logic [N-1:0] v, input logic [W*N-1:0] d, input bit ordy);
    logic [W*N-1:0] exp_port;
    logic [N-1:0]   exp_rdy;
    bit             acc [N];
    int             w;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    for (int i = 0; i < N; i++) begin
      exp_port[i*W +: W] = m_hold[i];
      exp_rdy[i]         = !r && !m_full[i];
    end
    check_val("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check_val("selector",  32'(bus.selector),  32'(m_sel));
    check_val("inputPort", 32'(bus.inputPort), 32'(exp_port));
    check_val("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) acc[i] = v[i] && !m_full[i];
      if (!m_valid) begin
        w = pick(-1);
        if (w >= 0) begin
          m_valid = 1'b1;
          m_sel   = w;
        end
      end else if (ordy) begin
        check_val("sb_depth", 32'(sb[m_sel].size()), 32'd1);
        if (sb[m_sel].size() > 0)
          check_val("conserve", 32'(W'(bus.inputPort >> (m_sel * W))), 32'(sb[m_sel].pop_front()));
        hs_sel.push_back(m_sel);
        m_full[m_sel] = 1'b0;
        m_last        = m_sel;
        w             = pick(m_sel);
        if (w >= 0) m_sel = w;
        else        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          m_full[i] = 1'b1;
          m_hold[i] = d[i*W +: W];
          sb[i].push_back(d[i*W +: W]);
        end
      end
    end
  endtask

  initial begin
    int cyc;
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // reset, then single word on channel 1
    repeat (3) cycle(1'b1, 2'b00, 8'h00, 1'b0);
    cycle(1'b0, 2'b10, 8'hA0, 1'b1);
    repeat (4) cycle(1'b0, 2'b00, 8'h00, 1'b1);

    // both channels on the same edge
    cycle(1'b0, 2'b11, 8'h53, 1'b1);
    repeat (4) cycle(1'b0, 2'b00, 8'h00, 1'b1);

    // back-pressure with channel 1 pending
    cycle(1'b0, 2'b01, 8'h07, 1'b0);
    cycle(1'b0, 2'b10, 8'hC0, 1'b0);
    repeat (5) cycle(1'b0, 2'b11, 8'hFF, 1'b0);
    repeat (4) cycle(1'b0, 2'b00, 8'h00, 1'b1);

    // fairness with both channels continuously refilled
    cycle(1'b1, 2'b00, 8'h00, 1'b0);
    hs_sel.delete();
    cyc = 0;
    while (hs_sel.size() < 20 && cyc < 200) begin
      cycle(1'b0, 2'b11, 8'($urandom), 1'b1);
      cyc++;
    end
    check_val("fair_budget", 32'(cyc < 200), 32'd1);
`ifndef MUX_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < hs_sel.size() && i < 20; i++)
      check_val("fair_alt", 32'(hs_sel[i]), 32'(i % 2));
`endif

    // reset while granted with both channels full
    cycle(1'b0, 2'b11, 8'h21, 1'b0);
    repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b0);
    cycle(1'b1, 2'b11, 8'h99, 1'b1);
    cycle(1'b0, 2'b00, 8'h00, 1'b1);
    cycle(1'b0, 2'b11, 8'h64, 1'b0);
    repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b1);

    // random traffic
    for (int t = 0; t < 600; t++)
      cycle(($urandom % 60) == 0, N'($urandom), (W*N)'($urandom), 1'($urandom));
    repeat (6) cycle(1'b0, 2'b00, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
